// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending controller with coin/selection reject,
// idle-timeout refund and timed vend/change phases; money is in half-yuan units.
module vend_ctrl_multi #(
   parameter int N_DRINK    = 4,
   parameter int SUM_W      = 8,
   parameter logic [N_DRINK*SUM_W-1:0] PRICES = {8'd20, 8'd14, 8'd10, 8'd5},
   parameter int COIN1_Q    = 1,
   parameter int COIN2_Q    = 2,
   parameter int COIN3_Q    = 10,
   parameter int MAX_SUM    = 63,
   parameter int TIMEOUT    = 1000,
   parameter int VEND_CYC   = 4,
   parameter int CHARGE_CYC = 4,
   localparam int SEL_W     = $clog2(N_DRINK + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               insert,
   input  logic [1:0]         coin_val,
   input  logic [SEL_W-1:0]   drink_op,
   input  logic               cancel_flag,
   output logic               hold_ind,
   output logic [N_DRINK-1:0] avail_ind,
   output logic               drinktk_ind,
   output logic               charge_ind,
   output logic               reject_ind,
   output logic [SUM_W-1:0]   coin_sum
);

   localparam int PH_MAX = (VEND_CYC > CHARGE_CYC) ? VEND_CYC : CHARGE_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TMR_W  = $clog2(TIMEOUT + 1);
   localparam logic [SUM_W:0] MAX_EXT = (SUM_W + 1)'(MAX_SUM);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_VEND, S_CHARGE} state_t;

   state_t             r_state, w_state_nx;
   logic [SUM_W-1:0]   r_sum, w_sum_nx;
   logic [TMR_W-1:0]   r_timer, w_timer_nx;
   logic [PH_W-1:0]    r_cnt, w_cnt_nx;
   logic               r_reject, w_reject_nx;
   logic               r_hold, r_drinktk, r_charge;
   logic [N_DRINK-1:0] r_avail, w_avail_nx;

   logic [SUM_W-1:0]   w_coin;
   logic               w_coin_vld;
   logic [SUM_W:0]     w_sum_add;
   logic               w_coin_fits;
   logic [SUM_W-1:0]   w_sel_price;
   logic               w_sel_hit;
   logic               w_sel_ok;

   always_comb begin
      w_coin = '0;
      case (coin_val)
         2'b01:   w_coin = SUM_W'(COIN1_Q);
         2'b10:   w_coin = SUM_W'(COIN2_Q);
         2'b11:   w_coin = SUM_W'(COIN3_Q);
         default: w_coin = '0;
      endcase
   end

   // extra headroom bit so an overflowing coin is seen as overflow, not a wrapped small sum
   assign w_coin_vld  = insert && (coin_val != 2'b00);
   assign w_sum_add   = {1'b0, r_sum} + {1'b0, w_coin};
   assign w_coin_fits = (w_sum_add <= MAX_EXT);

   always_comb begin
      w_sel_price = '0;
      w_sel_hit   = 1'b0;
      for (int k = 1; k <= N_DRINK; k++) begin
         if (drink_op == SEL_W'(k)) begin
            w_sel_price = PRICES[(k-1)*SUM_W +: SUM_W];
            w_sel_hit   = 1'b1;
         end
      end
   end

   assign w_sel_ok = w_sel_hit && (r_sum >= w_sel_price);

   always_comb begin
      w_state_nx  = r_state;
      w_sum_nx    = r_sum;
      w_timer_nx  = r_timer;
      w_cnt_nx    = r_cnt;
      w_reject_nx = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_coin_vld) begin
               if ({1'b0, w_coin} > MAX_EXT) begin
                  w_reject_nx = 1'b1;
               end else begin
                  w_state_nx = S_HOLD;
                  w_sum_nx   = w_coin;
                  w_timer_nx = '0;
               end
            end
         end
         S_HOLD: begin
            if (cancel_flag) begin
               w_state_nx = S_CHARGE;
               w_cnt_nx   = '0;
            end else if (drink_op != '0) begin
               w_timer_nx = '0;
               if (w_sel_ok) begin
                  w_state_nx = S_VEND;
                  w_sum_nx   = r_sum - w_sel_price;
                  w_cnt_nx   = '0;
               end else begin
                  w_reject_nx = 1'b1;
               end
            end else if (w_coin_vld) begin
               w_timer_nx = '0;
               if (w_coin_fits) w_sum_nx = w_sum_add[SUM_W-1:0];
               else             w_reject_nx = 1'b1;
            end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
               w_state_nx = S_CHARGE;
               w_cnt_nx   = '0;
            end else begin
               w_timer_nx = r_timer + 1'b1;
            end
         end
         S_VEND: begin
            if (r_cnt == PH_W'(VEND_CYC - 1)) begin
               w_cnt_nx   = '0;
               w_state_nx = (r_sum != '0) ? S_CHARGE : S_IDLE;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         S_CHARGE: begin
            if (r_cnt == PH_W'(CHARGE_CYC - 1)) begin
               w_cnt_nx   = '0;
               w_state_nx = S_IDLE;
               w_sum_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_sum_nx   = '0;
         end
      endcase
   end

   always_comb begin
      w_avail_nx = '0;
      for (int k = 0; k < N_DRINK; k++) begin
         w_avail_nx[k] = (w_state_nx == S_HOLD) && (w_sum_nx >= PRICES[k*SUM_W +: SUM_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_sum     <= '0;
         r_timer   <= '0;
         r_cnt     <= '0;
         r_reject  <= 1'b0;
         r_hold    <= 1'b0;
         r_drinktk <= 1'b0;
         r_charge  <= 1'b0;
         r_avail   <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_sum     <= w_sum_nx;
         r_timer   <= w_timer_nx;
         r_cnt     <= w_cnt_nx;
         r_reject  <= w_reject_nx;
         r_hold    <= (w_state_nx != S_IDLE);
         r_drinktk <= (w_state_nx == S_VEND);
         r_charge  <= (w_state_nx == S_CHARGE);
         r_avail   <= w_avail_nx;
      end
   end

   assign hold_ind    = r_hold;
   assign avail_ind   = r_avail;
   assign drinktk_ind = r_drinktk;
   assign charge_ind  = r_charge;
   assign reject_ind  = r_reject;
   assign coin_sum    = r_sum;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - scoreboard bench for vend_ctrl_multi with directed and random stimulus
module tb_vend_ctrl_multi;

   localparam int TO      = 30;
   localparam int MAXS    = 63;
   localparam int VCYC    = 4;
   localparam int CCYC    = 4;
   localparam int PRICE_Q [4] = '{5, 10, 14, 20};

   typedef struct packed {
      logic       hold;
      logic [3:0] avail;
      logic       drinktk;
      logic       charge;
      logic       reject;
      logic [7:0] sum;
   } obs_t;

   logic       clk;
   logic       rst_n;
   logic       insert;
   logic [1:0] coin_val;
   logic [2:0] drink_op;
   logic       cancel_flag;
   logic       hold_ind;
   logic [3:0] avail_ind;
   logic       drinktk_ind;
   logic       charge_ind;
   logic       reject_ind;
   logic [7:0] coin_sum;

   vend_ctrl_multi #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .insert      (insert),
      .coin_val    (coin_val),
      .drink_op    (drink_op),
      .cancel_flag (cancel_flag),
      .hold_ind    (hold_ind),
      .avail_ind   (avail_ind),
      .drinktk_ind (drinktk_ind),
      .charge_ind  (charge_ind),
      .reject_ind  (reject_ind),
      .coin_sum    (coin_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   obs_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;
   obs_t  got;
   obs_t  mon_e;
   string mon_t;

   assign got = {hold_ind, avail_ind, drinktk_ind, charge_ind, reject_ind, coin_sum};

   // reference machine: mode 0 idle, 1 holding money, 2 dispensing, 3 returning change
   int m_mode  = 0;
   int m_money = 0;
   int m_left  = 0;
   int m_quiet = 0;
   bit m_rej   = 0;

   function automatic int coin_q(input logic [1:0] v);
      case (v)
         2'b01:   return 1;
         2'b10:   return 2;
         2'b11:   return 10;
         default: return 0;
      endcase
   endfunction

   task automatic model(input bit rn, input bit ins, input logic [1:0] cv,
                        input int sel, input bit can, output obs_t o);
      int  c;
      bit  has_coin;
      c        = coin_q(cv);
      has_coin = ins && (cv != 2'b00);
      m_rej    = 0;
      if (!rn) begin
         m_mode = 0; m_money = 0; m_left = 0; m_quiet = 0;
      end else begin
         case (m_mode)
            0: if (has_coin) begin
                  if (c > MAXS) m_rej = 1;
                  else begin m_mode = 1; m_money = c; m_quiet = 0; end
               end
            1: if (can) begin
                  m_mode = 3; m_left = CCYC;
               end else if (sel != 0) begin
                  m_quiet = 0;
                  if (sel <= 4 && m_money >= PRICE_Q[sel-1]) begin
                     m_money -= PRICE_Q[sel-1];
                     m_mode = 2; m_left = VCYC;
                  end else m_rej = 1;
               end else if (has_coin) begin
                  m_quiet = 0;
                  if (m_money + c <= MAXS) m_money += c;
                  else m_rej = 1;
               end else begin
                  m_quiet++;
                  if (m_quiet == TO) begin m_mode = 3; m_left = CCYC; end
               end
            2: begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_money > 0) begin m_mode = 3; m_left = CCYC; end
                     else m_mode = 0;
                  end
               end
            default: begin
                  m_left--;
                  if (m_left == 0) begin m_mode = 0; m_money = 0; end
               end
         endcase
      end
      o.hold    = (m_mode != 0);
      for (int k = 0; k < 4; k++) o.avail[k] = (m_mode == 1) && (m_money >= PRICE_Q[k]);
      o.drinktk = (m_mode == 2);
      o.charge  = (m_mode == 3);
      o.reject  = m_rej;
      o.sum     = 8'(m_money);
   endtask

   task automatic step(input bit rn, input bit ins, input logic [1:0] cv,
                       input int sel, input bit can, input string tag);
      obs_t e;
      @(negedge clk);
      rst_n = rn; insert = ins; coin_val = cv; drink_op = 3'(sel); cancel_flag = can;
      model(rn, ins, cv, sel, can, e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1, 0, 2'b00, 0, 0, tag);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (got !== mon_e) begin
               errors++;
               $display("FAIL %s t=%0t got hold=%0b avail=%b drk=%0b chg=%0b rej=%0b sum=%0d want hold=%0b avail=%b drk=%0b chg=%0b rej=%0b sum=%0d",
                        mon_t, $time, got.hold, got.avail, got.drinktk, got.charge, got.reject, got.sum,
                        mon_e.hold, mon_e.avail, mon_e.drinktk, mon_e.charge, mon_e.reject, mon_e.sum);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; insert = 1'b0; coin_val = 2'b00; drink_op = 3'd0; cancel_flag = 1'b0;
      step(0, 0, 2'b00, 0, 0, "reset");
      step(0, 1, 2'b11, 2, 1, "reset_busy_inputs");

      step(1, 1, 2'b11, 0, 0, "coin5y");
      step(1, 0, 2'b00, 2, 0, "sel2");
      idle(6, "vend2_no_change");

      for (int i = 0; i < 3; i++) step(1, 1, 2'b01, 0, 0, "half_held");
      step(1, 0, 2'b00, 0, 1, "cancel");
      idle(6, "refund3");

      step(1, 1, 2'b11, 0, 0, "coin10");
      step(1, 0, 2'b00, 3, 0, "rej_price");
      step(1, 0, 2'b00, 5, 0, "rej_range");
      step(1, 0, 2'b00, 0, 1, "cancel10");
      idle(6, "refund10");

      for (int i = 0; i < 7; i++) step(1, 1, 2'b11, 0, 0, "cap_coins");
      step(1, 0, 2'b00, 1, 0, "sel1_cap");
      idle(10, "change55");

      step(1, 1, 2'b10, 0, 0, "coin1y");
      step(1, 1, 2'b11, 1, 1, "priority");
      idle(6, "prio_refund");

      step(1, 1, 2'b10, 0, 0, "coin1y_to");
      idle(TO + 6, "timeout");

      step(1, 1, 2'b11, 0, 0, "coin_rv");
      step(1, 0, 2'b00, 1, 0, "sel1_rv");
      idle(1, "vend_rv");
      step(0, 0, 2'b00, 0, 0, "rst_in_vend");
      idle(3, "post_rst");

      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 199);
         if (r == 0) begin
            step(0, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 0, 0, "rnd_rst");
         end else if (r < 5) begin
            idle($urandom_range(1, TO + 4), "rnd_idle");
         end else begin
            step(1, $urandom_range(0, 99) < 40, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 15) ? $urandom_range(1, 7) : 0,
                 $urandom_range(0, 99) < 3, "rnd");
         end
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
